// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles the fetch, data and SRAM-side signals of the SRAM port arbiter.
//   slave  : arbiter view (takes requests, drives grants/responses and the SRAM port)
//   master : requester/memory view (drives requests and mem_rdata)
//   Fetch : inst_req, inst_addr, inst_flush -> inst_gnt, inst_rvalid, inst_rdata
//   Data  : data_req, data_wen, data_addr, data_wdata -> data_gnt, data_rvalid, data_rdata
//   SRAM  : mem_en, mem_wen, mem_addr, mem_wdata <- mem_rdata
//   Stall : stallreq_if, stallreq_ex
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        inst_flush;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stallreq_if;
    logic        stallreq_ex;

    modport slave (
        input  inst_req, inst_addr, inst_flush,
        input  data_req, data_wen, data_addr, data_wdata,
        input  mem_rdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        output stallreq_if, stallreq_ex
    );

    modport master (
        output inst_req, inst_addr, inst_flush,
        output data_req, data_wen, data_addr, data_wdata,
        output mem_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        input  stallreq_if, stallreq_ex
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port synchronous SRAM between instruction fetch and
//   data access. Data wins arbitration unless fetch has been denied
//   MAX_STARVE cycles in a row. Granted reads are tagged with their source
//   in a LATENCY-deep shift register so the returning SRAM data is steered
//   to the right requester; a branch flush kills in-flight fetch tags.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous reset, active low
//     bus  - sram_port_arbiter_if.slave (fetch, data, SRAM and stall signals)
module sram_port_arbiter #(
    parameter int LATENCY    = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_STARVE);

    logic [CW-1:0]    starve_q, starve_d;
    logic [LATENCY:1] vld_pipe_q, vld_pipe_d;
    logic [LATENCY:1] src_pipe_q, src_pipe_d;   // 1 = fetch, 0 = data

    logic starve_win;
    logic inst_gnt;
    logic data_gnt;

    // Arbitration: data first, unless fetch has hit its starvation limit.
    assign starve_win = bus.inst_req && (starve_q == STARVE_MAX);
    assign inst_gnt   = bus.inst_req && (!bus.data_req || starve_win);
    assign data_gnt   = bus.data_req && !starve_win;

    assign bus.inst_gnt    = inst_gnt;
    assign bus.data_gnt    = data_gnt;
    assign bus.stallreq_if = bus.inst_req && !inst_gnt;
    assign bus.stallreq_ex = bus.data_req && !data_gnt;

    // SRAM port: idle cycles drive zeros so the bus carries no stale values.
    assign bus.mem_en    = inst_gnt || data_gnt;
    assign bus.mem_addr  = inst_gnt ? bus.inst_addr :
                           data_gnt ? bus.data_addr : 32'h0;
    assign bus.mem_wen   = data_gnt ? bus.data_wen : 4'b0000;
    assign bus.mem_wdata = (inst_gnt || data_gnt) ? bus.data_wdata : 32'h0;

    // Last tag stage selects the destination; flush masks a fetch response
    // presenting in the same cycle.
    assign bus.inst_rvalid = vld_pipe_q[LATENCY] && src_pipe_q[LATENCY] && !bus.inst_flush;
    assign bus.data_rvalid = vld_pipe_q[LATENCY] && !src_pipe_q[LATENCY];
    assign bus.inst_rdata  = bus.mem_rdata;
    assign bus.data_rdata  = bus.mem_rdata;

    always_comb begin
        starve_d = starve_q;
        if (inst_gnt || !bus.inst_req) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        vld_pipe_d = '0;
        src_pipe_d = '0;
        // A grant made in the flush cycle is younger than the redirect, so
        // stage 1 is loaded without the flush mask.
        vld_pipe_d[1] = inst_gnt || (data_gnt && (bus.data_wen == 4'b0000));
        src_pipe_d[1] = inst_gnt;
        for (int k = 2; k <= LATENCY; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1] && !(bus.inst_flush && src_pipe_q[k-1]);
            src_pipe_d[k] = src_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q   <= '0;
            vld_pipe_q <= '0;
            src_pipe_q <= '0;
        end else begin
            starve_q   <= starve_d;
            vld_pipe_q <= vld_pipe_d;
            src_pipe_q <= src_pipe_d;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Randomized plus directed stimulus; a reference model predicts grants,
//   SRAM drive and a queue of expected read responses (due cycle, source,
//   data from a reference memory). A negedge monitor pops and compares.
//   A behavioural SRAM answers the DUT's own memory port.
module tb_sram_port_arbiter;
    localparam int L  = 3;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus();

    sram_port_arbiter #(.LATENCY(L), .MAX_STARVE(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        bit          src;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          armed = 1'b0;
    int          starve = 0;
    logic [8:0]  e_arb;
    logic [63:0] e_bus;

    logic [31:0] ref_mem  [bit [29:0]];
    logic [31:0] sram_mem [bit [29:0]];
    logic [31:0] rp [L];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_word(a);
    endfunction

    function automatic logic [31:0] sram_read(logic [31:0] a);
        if (sram_mem.exists(a[31:2])) return sram_mem[a[31:2]];
        return init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the reference model's prediction.
    task automatic step(input bit r, input bit ir, input logic [31:0] ia, input bit fl,
                        input bit dr, input logic [3:0] we, input logic [31:0] da,
                        input logic [31:0] wd);
        bit sw, ig, dg;
        @(posedge clk);
        #1;
        cyc++;
        rst            = r;
        bus.inst_req   = ir;
        bus.inst_addr  = ia;
        bus.inst_flush = fl;
        bus.data_req   = dr;
        bus.data_wen   = we;
        bus.data_addr  = da;
        bus.data_wdata = wd;

        sw = ir && (starve == MS);
        ig = ir && (!dr || sw);
        dg = dr && !sw;
        e_arb = {ig, dg, ig || dg, dg ? we : 4'b0000, ir && !ig, dr && !dg};
        e_bus = {ig ? ia : (dg ? da : 32'h0), (ig || dg) ? wd : 32'h0};

        if (fl)
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].src) exp_q.delete(i);
        if (!r)
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].due > cyc) exp_q.delete(i);
        if (r && (ig || (dg && we == 4'b0000)))
            exp_q.push_back('{due: cyc + L, src: ig, data: ref_read(ig ? ia : da)});
        if (dg && we != 4'b0000)
            ref_mem[da[31:2]] = merge(ref_read(da), wd, we);
        if (!r || ig || !ir) starve = 0;
        else if (starve < MS) starve++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    // Behavioural SRAM driven by the DUT's memory port.
    always begin : sram_model
        logic        en;
        logic [3:0]  we;
        logic [31:0] a, wd, rd;
        @(negedge clk);
        en = bus.mem_en;
        we = bus.mem_wen;
        a  = bus.mem_addr;
        wd = bus.mem_wdata;
        @(posedge clk);
        #1;
        rd = $urandom;
        if (en && we == 4'b0000) rd = sram_read(a);
        if (en && we != 4'b0000) sram_mem[a[31:2]] = merge(sram_read(a), wd, we);
        for (int k = L - 1; k > 0; k--) rp[k] = rp[k-1];
        rp[0] = rd;
        bus.mem_rdata = rp[L-1];
    end

    // Monitor: compares combinational outputs and pops due responses.
    always @(negedge clk) begin : monitor
        int fi, di;
        fi = -1;
        di = -1;
        foreach (exp_q[i])
            if (exp_q[i].due == cyc) begin
                if (exp_q[i].src) fi = i;
                else di = i;
            end
        if (armed) begin
            chk("arb_stall", 64'({bus.inst_gnt, bus.data_gnt, bus.mem_en, bus.mem_wen,
                                  bus.stallreq_if, bus.stallreq_ex}), 64'(e_arb));
            chk("mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, e_bus);
            chk("inst_rvalid", 64'(bus.inst_rvalid), 64'(fi >= 0));
            chk("data_rvalid", 64'(bus.data_rvalid), 64'(di >= 0));
            if (fi >= 0 && bus.inst_rvalid)
                chk("inst_rdata", 64'(bus.inst_rdata), 64'(exp_q[fi].data));
            if (di >= 0 && bus.data_rvalid)
                chk("data_rdata", 64'(bus.data_rdata), 64'(exp_q[di].data));
        end
        if (fi > di) begin
            exp_q.delete(fi);
            if (di >= 0) exp_q.delete(di);
        end else if (di >= 0) begin
            exp_q.delete(di);
            if (fi >= 0) exp_q.delete(fi);
        end
    end

    initial begin
        rst            = 1'b0;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.inst_flush = 1'b0;
        bus.data_req   = 1'b0;
        bus.data_wen   = 4'b0000;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.mem_rdata  = 32'h0;
        for (int k = 0; k < L; k++) rp[k] = 32'h0;

        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        armed = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        idle(2);

        // Fetch stream alone.
        repeat (6) step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        idle(L + 1);

        // Load and fetch together: data wins.
        step(1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 1'b1, 4'b0000, 32'h8000_1000, 32'h0);
        idle(L + 1);

        // Sustained contention: fetch breaks through after MAX_STARVE denials.
        repeat (6) step(1'b1, 1'b1, 32'hBFC0_0008, 1'b0, 1'b1, 4'b0000, 32'h8000_1004, 32'h0);
        idle(L + 1);

        // Partial store, then read the merged word back from both sides.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h8000_0010, 32'h1234_5678);
        idle(L + 1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h8000_0010, 32'h0);
        step(1'b1, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        idle(L + 1);

        // Flush on the third of three back-to-back fetches.
        step(1'b1, 1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'hBFC0_0014, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'hBFC0_0018, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
        idle(L + 1);

        // Flush while a load response presents.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h8000_0020, 32'h0);
        step(1'b1, 1'b1, 32'hBFC0_0020, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
        idle(L + 1);

        // Reset with two reads in flight, then a clean grant.
        step(1'b1, 1'b1, 32'hBFC0_0030, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h8000_0030, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'hBFC0_0034, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        idle(L + 1);

        // Random traffic over a small shared address window.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ia, da, wd;
            logic [3:0]  we;
            ia = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            da = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            wd = $urandom;
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6, ia,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, we, da, wd);
        end
        idle(L + 2);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_responses actual=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the IF instruction-fetch requester and the EX data-access requester.
- Sits between the pipeline stages and the external memory port.
- Grants at most one access per cycle, tags reads so each response returns to the right requester, and raises per-stage stall requests for the stall controller.
- Supports a branch flush that discards in-flight fetch responses, and bounds fetch starvation.

Parameters:
- LATENCY, 1, SRAM read latency in cycles (legal 1..4); read data is valid LATENCY cycles after the enable.
- MAX_STARVE, 4, consecutive denied fetch cycles after which fetch wins arbitration (legal 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low: state clears on a rising edge where rst==0.
- inst_req  input  1  fetch request (always a read).
- inst_addr  input  32  fetch byte address.
- inst_gnt  output  1  fetch accepted this cycle.
- inst_rvalid  output  1  fetch response valid.
- inst_rdata  output  32  fetch response data.
- inst_flush  input  1  branch redirect: squash in-flight fetch responses.
- data_req  input  1  data request.
- data_wen  input  4  byte write enables; 4'b0000 means read.
- data_addr  input  32  data byte address.
- data_wdata  input  32  store data.
- data_gnt  output  1  data accepted this cycle.
- data_rvalid  output  1  load response valid.
- data_rdata  output  32  load response data.
- mem_en  output  1  SRAM enable.
- mem_wen  output  4  SRAM byte write enables.
- mem_addr  output  32  SRAM address.
- mem_wdata  output  32  SRAM write data.
- mem_rdata  input  32  SRAM read data.
- stallreq_if  output  1  fetch request pending but not granted.
- stallreq_ex  output  1  data request pending but not granted.

Behaviour:
- Reset (rst==0 at an edge) clears the tag pipeline and the starvation counter.
- After reset: all valid, grant and stall outputs are 0 as long as the requests are 0; mem_en=0, mem_wen=0.
- Arbitration (combinational, same cycle as the request):
  - data_req has priority.
  - Exception: when starve_cnt==MAX_STARVE and inst_req=1, fetch wins.
  - Only one of inst_gnt and data_gnt is asserted per cycle.
  - inst_gnt=1 requires inst_req=1; data_gnt=1 requires data_req=1.
- Memory drive:
  - Winner's address is driven to mem_addr.
  - mem_en equals the OR of the grants.
  - mem_wen is data_wen if data wins, otherwise 0.
  - mem_wdata is data_wdata.
  - When there is no grant, mem_addr, mem_wdata and mem_wen are 0.
- Stall requests:
  - stallreq_if = inst_req & ~inst_gnt.
  - stallreq_ex = data_req & ~data_gnt.
  - Both are combinational.
- Starvation counter, width ceil(log2(MAX_STARVE+1)):
  - Increments, saturating at MAX_STARVE, when stallreq_if=1.
  - Clears to 0 on inst_gnt or when inst_req=0.
- Tag pipeline:
  - LATENCY stages, each holding {valid, src}, where src=1 means fetch.
  - A granted read enters stage 1 at the next edge.
  - Writes generate no tag and no response.
  - Entries advance one stage per cycle unconditionally; there is no backpressure on responses.
- Responses:
  - For the last stage, tag {v, s}: inst_rvalid = v & s & ~inst_flush, and data_rvalid = v & ~s.
  - inst_rdata and data_rdata both pass mem_rdata through combinationally; they are meaningful only while the matching rvalid is high.
- Flush:
  - When inst_flush=1, every fetch-tagged entry in the pipeline, including the one presenting this cycle, has its valid bit cleared at the edge and its response is suppressed.
  - A fetch granted in the flush cycle itself is not squashed.
  - Data entries are never affected by flush.
- Simultaneous events:
  - Flush together with a new fetch grant: only older fetches are squashed.
  - Flush together with a data response: the data response is delivered.
  - A mid-operation reset drops all in-flight responses; no rvalid is asserted on the cycle after a reset edge.
- Arithmetic: none beyond the saturating counter; addresses pass through unmodified.

Test Plan:
- LATENCY=1, inst_req=1 with inst_addr=0xBFC00000 held, data_req=0 -> inst_gnt=1 every cycle; mem_addr=0xBFC00000; inst_rvalid=1 from cycle 2 onward with inst_rdata=mem_rdata.
- Both requesters active, data load addr 0x80001000, fetch 0xBFC00004 -> data_gnt=1, inst_gnt=0, stallreq_if=1; data_rvalid=1 next cycle, inst_rvalid=0.
- MAX_STARVE=4, data_req and inst_req held high for 6 cycles:
  - cycles 1-4 grant data, with starve_cnt counting 1..4;
  - cycle 5 grants fetch, stallreq_ex=1;
  - cycle 6 grants data, starve_cnt=0.
- Store with data_wen=4'b0011, addr 0x80000010, wdata 0x12345678 -> mem_en=1, mem_wen=4'b0011, mem_wdata=0x12345678; no data_rvalid on any later cycle.
- LATENCY=3, fetches granted on cycles 1, 2, 3, inst_flush=1 on cycle 3 -> responses from the cycle-1 and cycle-2 grants are suppressed; the cycle-3 grant's response is delivered on cycle 6.
- rst=0 for one edge while two reads are in flight -> after the edge, inst_rvalid=0, data_rvalid=0, starve_cnt=0; the next grant behaves as from a clean start.
